count_mod_n: RTL and testbench
==============================

// Module: count_mod_n
// PURPOSE
//   Parametrised modulo-N loadable up/down digit counter for the microwave timer datapath.
//   Generalises the fixed mod-10 down counter:
//   - any modulus (6 for tens-of-seconds, 10 for unit digits);
//   - selectable direction;
//   - wrap or halt at the terminal value;
//   - a sticky count_end flag.
//   Instances cascade: the tc output of one digit drives the en input of the next.
// PARAMETERS
//   MODULUS  10  number of states; count runs 0..MODULUS-1; MODULUS >= 2
//   WIDTH    4   count/data width; 2**WIDTH >= MODULUS is required
//   WRAP     1   1: wrap at the terminal value; 0: halt (hold) at the terminal value
// PORTS
//   clk        in   1      single clock; all state updates on posedge clk
//   clear      in   1      synchronous reset, active-high
//   data       in   WIDTH  parallel load value
//   load       in   1      synchronous parallel load, active-high
//   en         in   1      count enable (cascade input from the lower digit's tc)
//   up         in   1      1: count up; 0: count down
//   count      out  WIDTH  current count, registered
//   tc         out  1      terminal count, combinational
//   count_end  out  1      sticky "terminal value reached" flag, registered
// BEHAVIOUR
//   Timing
//   - One clock; reset is synchronous and active-high (clk, clear).
//   - Latency: every count/count_end change appears one posedge after the qualifying input.
//   Priority per posedge: clear > load > en > hold.
//   clear
//   - count <= 0, count_end <= 0.
//   - Reset values: count = 0, count_end = 0, tc = 0.
//   load (clear = 0)
//   - count <= (data > MODULUS-1) ? MODULUS-1 : data; out-of-range data saturates.
//   - count_end <= 0.
//   - en is ignored in a load cycle.
//   en = 1, up = 0 (count down)
//   - count != 0: count <= count-1.
//   - count == 0: count <= (WRAP ? MODULUS-1 : 0).
//   en = 1, up = 1 (count up)
//   - count != MODULUS-1: count <= count+1.
//   - count == MODULUS-1: count <= (WRAP ? 0 : MODULUS-1).
//   en = 0: count and count_end hold.
//   tc
//   - tc = en & ~load & ~clear & (up ? count == MODULUS-1 : count == 0).
//   - tc is purely combinational, so a cascade of digits advances in the same edge.
//   count_end
//   - Set on any posedge where tc = 1.
//   - Remains 1 until clear or load.
//   - With WRAP = 0, repeated en at the terminal value keeps count and count_end = 1 stable.
//   Direction and range
//   - up may change on any cycle; the new direction takes effect on that cycle's edge.
//     No internal direction state.
//   - count never leaves 0..MODULUS-1.
//   - Arithmetic is done in WIDTH bits; no wrap through 2**WIDTH is ever observable.
//   - clear asserted mid-count overrides load and en on that edge.
// TESTING (default MODULUS=10, WIDTH=4 unless stated)
//   T1 Reset
//      - clear = 1 for 2 cycles with load = en = 1, data = 8
//        -> count = 0, count_end = 0, tc = 0.
//   T2 Load then count down, WRAP = 1
//      - load data = 8 for 1 cycle, then en = 1, up = 0
//        -> count 8,7,..,1,0; tc = 1 only while count = 0.
//      - Next edge -> count = 9, count_end = 1.
//   T3 Saturating load and priority
//      - load data = 4'd12 -> count = 9.
//      - load = en = 1 with data = 3 -> count = 3 (load wins).
//      - clear = load = 1 -> count = 0.
//   T4 Up count
//      - load 7, en = 1, up = 1 -> 8, 9 (tc = 1), then 0, count_end = 1.
//      - Toggle up = 0 at count = 0 -> tc = 1 immediately; next edge count = 9.
//   T5 Halt mode, WRAP = 0
//      - load 2, en = 1, up = 0 -> 1, 0, then holds 0 for 5 more edges; count_end = 1.
//      - load 5 -> count = 5, count_end = 0.
//   T6 Cascade, MODULUS=6 tens digit + MODULUS=10 units digit
//      - tens.en = units.tc, load 1 and 0, units en = 1, down
//        -> 10 -> 09 -> 08 ... 00 -> 59 at the next edge.
//      - Both count_end flags set.

Source files
------------

// File: rtl/count_mod_n.sv
`default_nettype none
// ============================================================================
// Module   : count_mod_n
// Brief    : Loadable modulo-N up/down digit counter with wrap/halt mode,
//            combinational terminal count and sticky count_end flag.
// Revision : 1.0 - initial release
// ============================================================================
module count_mod_n #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             count_end
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic             c_wrap = (WRAP != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_count_end;
    logic             w_at_term;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_load_val;

    assign w_at_term  = up ? (r_count == c_max) : (r_count == c_zero);
    assign w_load_val = (data > c_max) ? c_max : data;

    // At the terminal value the next state is the opposite end (wrap) or
    // the terminal value itself (halt); never passes through 2**WIDTH.
    always_comb begin
        w_step = r_count;
        if (up) begin
            if (r_count == c_max)
                w_step = c_wrap ? c_zero : c_max;
            else
                w_step = r_count + 1'b1;
        end else begin
            if (r_count == c_zero)
                w_step = c_wrap ? c_max : c_zero;
            else
                w_step = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count     <= c_zero;
            r_count_end <= 1'b0;
        end else if (load) begin
            r_count     <= w_load_val;
            r_count_end <= 1'b0;
        end else if (en) begin
            r_count <= w_step;
            if (w_at_term)
                r_count_end <= 1'b1;
        end
    end

    assign count     = r_count;
    assign count_end = r_count_end;
    assign tc        = en & ~load & ~clear & w_at_term;

endmodule
`default_nettype wire

// File: tb/tb_count_mod_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_mod_n
// Brief    : Directed self-checking bench for count_mod_n (wrap, halt, cascade).
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_mod_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Wrapping mod-10 instance
    logic       clear_a = 1'b0, load_a = 1'b0, en_a = 1'b0, up_a = 1'b0;
    logic [3:0] data_a = 4'd0;
    logic [3:0] count_a;
    logic       tc_a, end_a;

    // Halting mod-10 instance
    logic       clear_b = 1'b0, load_b = 1'b0, en_b = 1'b0, up_b = 1'b0;
    logic [3:0] data_b = 4'd0;
    logic [3:0] count_b;
    logic       tc_b, end_b;

    // Cascade: mod-6 tens driven by mod-10 units tc
    logic       clear_c = 1'b0, load_c = 1'b0, en_u = 1'b0, up_c = 1'b0;
    logic [3:0] data_t = 4'd0, data_u = 4'd0;
    logic [3:0] count_t, count_u;
    logic       tc_t, tc_u, end_t, end_u;

    count_mod_n #(.MODULUS(10), .WIDTH(4), .WRAP(1)) u_wrap (
        .clk(clk), .clear(clear_a), .data(data_a), .load(load_a), .en(en_a),
        .up(up_a), .count(count_a), .tc(tc_a), .count_end(end_a));

    count_mod_n #(.MODULUS(10), .WIDTH(4), .WRAP(0)) u_halt (
        .clk(clk), .clear(clear_b), .data(data_b), .load(load_b), .en(en_b),
        .up(up_b), .count(count_b), .tc(tc_b), .count_end(end_b));

    count_mod_n #(.MODULUS(6), .WIDTH(4), .WRAP(1)) u_tens (
        .clk(clk), .clear(clear_c), .data(data_t), .load(load_c), .en(tc_u),
        .up(up_c), .count(count_t), .tc(tc_t), .count_end(end_t));

    count_mod_n #(.MODULUS(10), .WIDTH(4), .WRAP(1)) u_units (
        .clk(clk), .clear(clear_c), .data(data_u), .load(load_c), .en(en_u),
        .up(up_c), .count(count_u), .tc(tc_u), .count_end(end_u));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_a = 1; load_a = 1; en_a = 1; data_a = 4'd8;
        clear_b = 1; clear_c = 1;
        step(); step();
        #1;
        checks++; if (count_a !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count_a); end
        checks++; if (end_a !== 1'b0) begin failures++; $display("FAIL reset_end: got %0b expected 0", end_a); end
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL reset_tc: got %0b expected 0", tc_a); end
        clear_a = 0; load_a = 0; en_a = 0; clear_b = 0; clear_c = 0;
    endtask

    task automatic test_down_wrap();
        load_a = 1; data_a = 4'd8; step();
        load_a = 0; en_a = 1; up_a = 0;
        for (int exp_v = 8; exp_v >= 0; exp_v--) begin
            #1;
            checks++; if (count_a !== 4'(exp_v)) begin failures++; $display("FAIL down_count: got %0d expected %0d", count_a, exp_v); end
            checks++; if (tc_a !== (exp_v == 0)) begin failures++; $display("FAIL down_tc: got %0b expected %0b at %0d", tc_a, exp_v == 0, exp_v); end
            checks++; if (end_a !== 1'b0) begin failures++; $display("FAIL down_end_early: got %0b expected 0", end_a); end
            step();
        end
        checks++; if (count_a !== 4'd9) begin failures++; $display("FAIL down_wrap: got %0d expected 9", count_a); end
        checks++; if (end_a !== 1'b1) begin failures++; $display("FAIL down_end_set: got %0b expected 1", end_a); end
        en_a = 0;
    endtask

    task automatic test_load_priority();
        load_a = 1; data_a = 4'd12; step();
        checks++; if (count_a !== 4'd9) begin failures++; $display("FAIL sat_load: got %0d expected 9", count_a); end
        checks++; if (end_a !== 1'b0) begin failures++; $display("FAIL load_clears_end: got %0b expected 0", end_a); end
        en_a = 1; data_a = 4'd3; #1;
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL load_masks_tc: got %0b expected 0", tc_a); end
        step();
        checks++; if (count_a !== 4'd3) begin failures++; $display("FAIL load_over_en: got %0d expected 3", count_a); end
        clear_a = 1; step();
        checks++; if (count_a !== 4'd0) begin failures++; $display("FAIL clear_over_load: got %0d expected 0", count_a); end
        clear_a = 0; load_a = 0; en_a = 0;
    endtask

    task automatic test_up();
        load_a = 1; data_a = 4'd7; step();
        load_a = 0; en_a = 1; up_a = 1; #1;
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL up_tc7: got %0b expected 0", tc_a); end
        step();
        checks++; if (count_a !== 4'd8) begin failures++; $display("FAIL up_8: got %0d expected 8", count_a); end
        step();
        checks++; if (count_a !== 4'd9) begin failures++; $display("FAIL up_9: got %0d expected 9", count_a); end
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL up_tc9: got %0b expected 1", tc_a); end
        checks++; if (end_a !== 1'b0) begin failures++; $display("FAIL up_end_early: got %0b expected 0", end_a); end
        step();
        checks++; if (count_a !== 4'd0) begin failures++; $display("FAIL up_wrap: got %0d expected 0", count_a); end
        checks++; if (end_a !== 1'b1) begin failures++; $display("FAIL up_end: got %0b expected 1", end_a); end
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL up_tc0: got %0b expected 0", tc_a); end
        up_a = 0; #1;
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL dir_tc: got %0b expected 1", tc_a); end
        step();
        checks++; if (count_a !== 4'd9) begin failures++; $display("FAIL dir_count: got %0d expected 9", count_a); end
        en_a = 0;
    endtask

    task automatic test_halt();
        load_b = 1; data_b = 4'd2; step();
        load_b = 0; en_b = 1; up_b = 0;
        step();
        checks++; if (count_b !== 4'd1) begin failures++; $display("FAIL halt_1: got %0d expected 1", count_b); end
        step();
        checks++; if (count_b !== 4'd0) begin failures++; $display("FAIL halt_0: got %0d expected 0", count_b); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (count_b !== 4'd0) begin failures++; $display("FAIL halt_hold: got %0d expected 0 at edge %0d", count_b, i); end
            checks++; if (end_b !== 1'b1) begin failures++; $display("FAIL halt_end: got %0b expected 1 at edge %0d", end_b, i); end
        end
        en_b = 0; load_b = 1; data_b = 4'd5; step();
        checks++; if (count_b !== 4'd5) begin failures++; $display("FAIL halt_reload: got %0d expected 5", count_b); end
        checks++; if (end_b !== 1'b0) begin failures++; $display("FAIL halt_reload_end: got %0b expected 0", end_b); end
        load_b = 0;
    endtask

    task automatic test_cascade();
        int v;
        load_c = 1; data_t = 4'd1; data_u = 4'd0; en_u = 0; up_c = 0; step();
        load_c = 0; en_u = 1;
        v = 10;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (count_t !== 4'(v / 10) || count_u !== 4'(v % 10)) begin
                failures++;
                $display("FAIL cascade: got %0d%0d expected %0d", count_t, count_u, v);
            end
            step();
            v = (v == 0) ? 59 : v - 1;
        end
        checks++; if (end_u !== 1'b1) begin failures++; $display("FAIL cascade_end_u: got %0b expected 1", end_u); end
        checks++; if (end_t !== 1'b1) begin failures++; $display("FAIL cascade_end_t: got %0b expected 1", end_t); end
        en_u = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_down_wrap();
        test_load_priority();
        test_up();
        test_halt();
        test_cascade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
